adc_spi_sequencer: RTL and testbench
====================================

Name: adc_spi_sequencer

Overview:
- Parametrised multi-channel SPI ADC controller for LTC2308-class converters; CS_N doubles as CONVST.
- Sweeps a programmable channel mask in single-shot or continuous mode and handles the converter's one-frame result pipeline.
- Stores per-channel results and exposes control, status and results on an Avalon-MM slave with an interrupt.
- Sits in the system as the successor to the fixed ADC core and drives the adc_sclk / adc_cs_n / adc_din / adc_dout pins.

Parameters:
- NUM_CH, 8: channels supported, 1..8.
- DATA_W, 12: result bits per frame, and SCLK periods per frame. DATA_W >= CFG_W.
- CFG_W, 6: config word bits shifted out MSB first.
- SCLK_DIV, 4: SCLK half-period in clk cycles, >= 1.
- CONV_CYCLES, 80: clk cycles CS_N is held high per conversion, >= 2.

Ports:
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- avs_address, in, 4: register word address.
- avs_read, in, 1: read strobe.
- avs_write, in, 1: write strobe.
- avs_writedata, in, 32: write data.
- avs_readdata, out, 32: read data, valid 1 cycle after avs_read.
- irq, out, 1: level interrupt, = done & irq_en.
- adc_sclk, out, 1: SPI clock.
- adc_cs_n, out, 1: chip select / CONVST.
- adc_din, out, 1: config data to ADC.
- adc_dout, in, 1: result data from ADC.

Behaviour:
Reset values:
- adc_cs_n=1, adc_sclk=0, adc_din=0, irq=0, avs_readdata=0.
- All registers 0. FSM in IDLE.
- A reset asserted mid-frame aborts the frame: pins take their reset values on the next edge, and no partial result is stored.

Registers (no waitrequest, read latency 1):
- 0 CTRL (RW):
  - [0] start: write-1 launches a sweep; always reads 0.
  - [1] continuous.
  - [2] irq_en.
  - [15:8] mask: bits >= NUM_CH are not written and read 0.
- 1 STATUS:
  - [0] busy (RO).
  - [1] done: sticky, write-1-to-clear.
- 8+i RESULT_i, i < NUM_CH (RO):
  - [DATA_W-1:0] last sample.
  - [31] valid: cleared by a read of that register. If a set and a read hit the same cycle, set wins.
- Unmapped addresses read 0; writes to them are ignored.

Start rules:
- Start with mask==0 is ignored.
- Start while busy is ignored.
- The mask is latched at sweep start; CTRL writes mid-sweep take effect at the next sweep.

Sweep:
- With N enabled channels c0<c1<..., a sweep is N+1 frames.
- Frame k sends the config for c_k and receives the result of c_(k-1).
- Frame 0's received data is discarded.
- Frame N (trailing) resends the config for c_(N-1) and delivers c_(N-1)'s result.

Config word per channel ch: {1, ch[0], ch[2], ch[1], 1, 0}, i.e. single-ended, unipolar, no sleep.

FSM:
- IDLE: on an accepted start, set busy and go to CONV.
- CONV: cs_n=1, sclk=0 for CONV_CYCLES cycles, then go to SHIFT.
- SHIFT:
  - cs_n=0 for DATA_W SCLK periods (2*SCLK_DIV*DATA_W cycles); sclk starts low.
  - din carries config bit j (MSB first) during period j; bits j >= CFG_W are 0.
  - Bit 0 is presented when cs_n falls; later bits change on sclk falling edges.
  - dout is sampled on each sclk rising edge (clk edge where sclk goes 0->1) into a shift register, MSB first.
  - Then go to STORE.
- STORE (1 cycle):
  - cs_n=1, sclk=0. Write the result and set valid, except in frame 0.
  - If frames remain, go to CONV.
  - Otherwise set done:
    - if continuous=1, start a new sweep (re-latch mask) and go to CONV;
    - else clear busy and go to IDLE.
  - If continuous is cleared mid-sweep, the current sweep completes, then the FSM goes to IDLE.
  - If a continuous-mode re-latch sees mask==0, clear busy and go to IDLE.

Timing:
- Frame length = CONV_CYCLES + 2*SCLK_DIV*DATA_W + 1 cycles.
- irq is registered and follows done & irq_en by 1 cycle.

Test Plan:
1. Reset check: hold reset for 3 cycles, then release → cs_n=1, sclk=0, din=0, irq=0. STATUS and all RESULT registers read 0. Assert reset mid-SHIFT → pins return to reset values the next cycle and no RESULT valid is set.
2. Single-shot, mask=0x05, irq_en=1; ADC model returns 0xA00+ch for the previously configured channel → 3 frames. din words are 100010, 100110, 100110. RESULT0 (addr 8)=0x80000A00, RESULT2 (addr 10)=0x80000A02. done=1, irq=1, busy=0. Re-reading addr 8 → 0x00000A00.
3. Timing with SCLK_DIV=4, DATA_W=12, CONV_CYCLES=80 → cs_n low for exactly 96 cycles per frame with exactly 12 sclk rising edges. Frame period 177 cycles; sclk period 8 cycles.
4. Ignored starts: start with mask=0 → busy stays 0 and no frames are issued. Start while busy → sweep length unchanged at N+1 frames.
5. Continuous mode, mask=0x80 → back-to-back 2-frame sweeps with done set each sweep. Clear continuous during frame 0 → frame 1 completes, then IDLE with busy=0. W1C on done → irq drops the next cycle.
6. Collision: read RESULT_i in the same cycle STORE writes it → valid reads back 1 on the following read.

Source files
------------

// File: rtl/adc_spi_sequencer_if.sv
// Avalon-MM slave bus bundle for adc_spi_sequencer.
//   avs_address   : register word address (4 bits)
//   avs_read      : read strobe, data returned one cycle later
//   avs_write     : write strobe
//   avs_writedata : write data (32 bits)
//   avs_readdata  : registered read data (32 bits)
//   irq           : level interrupt, done & irq_en
// The slave modport is used by the sequencer; the master modport by the bus owner.
interface adc_spi_sequencer_if;
  logic [3:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [31:0] avs_readdata;
  logic        irq;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_writedata,
    output avs_readdata, irq
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_writedata,
    input  avs_readdata, irq
  );
endinterface

// File: rtl/adc_spi_sequencer.sv
// Multi-channel SPI sequencer for LTC2308-class ADCs. CS_N doubles as CONVST.
// Sweeps a channel mask (single-shot or continuous), accounts for the
// converter's one-frame result pipeline and stores one result per channel.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   avs        : Avalon-MM slave (CTRL @0, STATUS @1, RESULT_i @8+i) plus irq
//   adc_sclk   : SPI clock, idles low
//   adc_cs_n   : chip select / conversion start
//   adc_din    : config word to the ADC, MSB first
//   adc_dout   : result data from the ADC, sampled on sclk rising edges
module adc_spi_sequencer #(
  parameter int NUM_CH      = 8,
  parameter int DATA_W      = 12,
  parameter int CFG_W       = 6,
  parameter int SCLK_DIV    = 4,
  parameter int CONV_CYCLES = 80
) (
  input  logic                      clk,
  input  logic                      reset,
  adc_spi_sequencer_if.slave        avs,
  output logic                      adc_sclk,
  output logic                      adc_cs_n,
  output logic                      adc_din,
  input  logic                      adc_dout
);

  localparam int CNT_W = $clog2(CONV_CYCLES);
  localparam int DIV_W = $clog2(SCLK_DIV) + 1;
  localparam int BIT_W = $clog2(DATA_W) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, CONV = 2'd1, SHIFT = 2'd2, STORE = 2'd3} state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [2:0]          cur_ch_q, cur_ch_d;    // channel configured this frame
  logic [2:0]          prev_ch_q, prev_ch_d;  // channel whose result arrives this frame
  logic                first_q, first_d;      // frame 0: received data is stale
  logic                trail_q, trail_d;      // trailing frame of the sweep
  logic [NUM_CH-1:0]   sweep_mask_q, sweep_mask_d;
  logic                cont_q, cont_d;
  logic                irq_en_q, irq_en_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   result_q [NUM_CH];
  logic [DATA_W-1:0]   result_d [NUM_CH];
  logic [NUM_CH-1:0]   valid_q, valid_d;
  logic [31:0]         readdata_q, readdata_d;
  logic                irq_q, irq_d;
  logic                sclk_q, sclk_d;
  logic                cs_n_q, cs_n_d;
  logic                din_q, din_d;

  logic                start_ok;
  logic [NUM_CH-1:0]   wr_mask;
  logic [2:0]          ridx;
  logic [3:0]          nxt_ch;
  logic                unused_ok;

  // Config bit j of the frame for channel ch: {1, ch[0], ch[2], ch[1], 1, 0}, zero padded.
  function automatic logic cfg_bit(input logic [2:0] ch, input int j);
    logic [5:0] w;
    w = {1'b1, ch[0], ch[2], ch[1], 1'b1, 1'b0};
    if ((j < CFG_W) && (j < 6)) return w[5-j];
    else return 1'b0;
  endfunction

  // Lowest enabled channel above 'after'; returns {found, channel}.
  function automatic logic [3:0] find_next(input logic [NUM_CH-1:0] m, input int after);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i] && (i > after)) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

  assign wr_mask   = avs.avs_writedata[8 +: NUM_CH];
  assign ridx      = avs.avs_address[2:0];
  assign unused_ok = ^avs.avs_writedata;

  assign adc_sclk         = sclk_q;
  assign adc_cs_n         = cs_n_q;
  assign adc_din          = din_q;
  assign avs.avs_readdata = readdata_q;
  assign avs.irq          = irq_q;

  // Next-state logic: register file, bus reads, sweep FSM and pin drive.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    div_d        = div_q;
    bit_d        = bit_q;
    shreg_d      = shreg_q;
    cur_ch_d     = cur_ch_q;
    prev_ch_d    = prev_ch_q;
    first_d      = first_q;
    trail_d      = trail_q;
    sweep_mask_d = sweep_mask_q;
    cont_d       = cont_q;
    irq_en_d     = irq_en_q;
    mask_d       = mask_q;
    busy_d       = busy_q;
    done_d       = done_q;
    result_d     = result_q;
    valid_d      = valid_q;
    readdata_d   = 32'd0;
    sclk_d       = sclk_q;
    cs_n_d       = cs_n_q;
    din_d        = din_q;
    start_ok     = 1'b0;
    nxt_ch       = 4'd0;

    if (avs.avs_write) begin
      case (avs.avs_address)
        4'd0: begin
          cont_d   = avs.avs_writedata[1];
          irq_en_d = avs.avs_writedata[2];
          mask_d   = wr_mask;
          start_ok = avs.avs_writedata[0] & ~busy_q & (|wr_mask);
        end
        4'd1:    done_d = done_q & ~avs.avs_writedata[1];
        default: done_d = done_q;
      endcase
    end else begin
      start_ok = 1'b0;
    end

    if (avs.avs_read) begin
      case (avs.avs_address)
        4'd0: begin
          readdata_d[1]            = cont_q;
          readdata_d[2]            = irq_en_q;
          readdata_d[8 +: NUM_CH]  = mask_q;
        end
        4'd1: readdata_d[1:0] = {done_q, busy_q};
        default: begin
          if (avs.avs_address[3] && (int'(ridx) < NUM_CH)) begin
            readdata_d[31]         = valid_q[ridx];
            readdata_d[DATA_W-1:0] = result_q[ridx];
            valid_d[ridx]          = 1'b0;
          end else begin
            readdata_d = 32'd0;
          end
        end
      endcase
    end else begin
      readdata_d = 32'd0;
    end

    // The FSM section comes after the bus section so a STORE set wins
    // over a same-cycle valid read-clear or done write-1-to-clear.
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          nxt_ch       = find_next(wr_mask, -1);
          sweep_mask_d = wr_mask;
          cur_ch_d     = nxt_ch[2:0];
          prev_ch_d    = nxt_ch[2:0];
          first_d      = 1'b1;
          trail_d      = 1'b0;
          busy_d       = 1'b1;
          cnt_d        = '0;
          state_d      = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        if (cnt_q == CNT_W'(CONV_CYCLES - 1)) begin
          state_d = SHIFT;
          cs_n_d  = 1'b0;
          sclk_d  = 1'b0;
          din_d   = cfg_bit(cur_ch_q, 0);
          div_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        if (div_q == DIV_W'(SCLK_DIV - 1)) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            shreg_d = {shreg_q[DATA_W-2:0], adc_dout};
          end else if (bit_q == BIT_W'(DATA_W - 1)) begin
            state_d = STORE;
            cs_n_d  = 1'b1;
            sclk_d  = 1'b0;
            din_d   = 1'b0;
          end else begin
            bit_d = bit_q + 1'b1;
            din_d = cfg_bit(cur_ch_q, int'(bit_q) + 1);
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      STORE: begin
        if (!first_q) begin
          result_d[prev_ch_q] = shreg_q;
          valid_d[prev_ch_q]  = 1'b1;
        end else begin
          valid_d = valid_d;
        end
        cnt_d   = '0;
        first_d = 1'b0;
        if (!trail_q) begin
          // More frames: advance to the next channel, or resend the last one.
          nxt_ch    = find_next(sweep_mask_q, int'(cur_ch_q));
          prev_ch_d = cur_ch_q;
          if (nxt_ch[3]) cur_ch_d = nxt_ch[2:0];
          else           trail_d  = 1'b1;
          state_d = CONV;
        end else begin
          done_d = 1'b1;
          if (cont_q && (|mask_q)) begin
            nxt_ch       = find_next(mask_q, -1);
            sweep_mask_d = mask_q;
            cur_ch_d     = nxt_ch[2:0];
            prev_ch_d    = nxt_ch[2:0];
            first_d      = 1'b1;
            trail_d      = 1'b0;
            state_d      = CONV;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    irq_d = done_q & irq_en_q;
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      div_q        <= '0;
      bit_q        <= '0;
      shreg_q      <= '0;
      cur_ch_q     <= 3'd0;
      prev_ch_q    <= 3'd0;
      first_q      <= 1'b0;
      trail_q      <= 1'b0;
      sweep_mask_q <= '0;
      cont_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      mask_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      result_q     <= '{default: '0};
      valid_q      <= '0;
      readdata_q   <= 32'd0;
      irq_q        <= 1'b0;
      sclk_q       <= 1'b0;
      cs_n_q       <= 1'b1;
      din_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_q        <= div_d;
      bit_q        <= bit_d;
      shreg_q      <= shreg_d;
      cur_ch_q     <= cur_ch_d;
      prev_ch_q    <= prev_ch_d;
      first_q      <= first_d;
      trail_q      <= trail_d;
      sweep_mask_q <= sweep_mask_d;
      cont_q       <= cont_d;
      irq_en_q     <= irq_en_d;
      mask_q       <= mask_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      result_q     <= result_d;
      valid_q      <= valid_d;
      readdata_q   <= readdata_d;
      irq_q        <= irq_d;
      sclk_q       <= sclk_d;
      cs_n_q       <= cs_n_d;
      din_q        <= din_d;
    end
  end

endmodule

// File: tb/tb_adc_spi_sequencer.sv
// Directed self-checking bench for adc_spi_sequencer with a behavioural
// LTC2308-style ADC: it answers each frame with 0xA00 + the channel that was
// configured in the previous frame, and logs config words and pin timing.
module tb_adc_spi_sequencer;
  localparam int CLK_P = 10;

  logic clk = 1'b0;
  logic reset;
  logic adc_sclk, adc_cs_n, adc_din;
  logic adc_dout = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  adc_spi_sequencer_if bus();

  adc_spi_sequencer #(
    .NUM_CH(8), .DATA_W(12), .CFG_W(6), .SCLK_DIV(4), .CONV_CYCLES(80)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .avs      (bus),
    .adc_sclk (adc_sclk),
    .adc_cs_n (adc_cs_n),
    .adc_din  (adc_din),
    .adc_dout (adc_dout)
  );

  always #5 clk = ~clk;

  // ---------------- ADC model and pin monitor ----------------
  logic        prev_cs   = 1'b1;
  logic        prev_sclk = 1'b0;
  logic [11:0] tx_sr     = 12'd0;
  logic [11:0] rx_sr     = 12'd0;
  logic [11:0] pending   = 12'd0;
  logic [5:0]  cfg_w;
  int          fall_cnt  = 0;
  int          rise_in_frame = 0;
  longint      t_fall    = 0;
  logic [5:0]  cfg_log[$];
  int          low_log[$];
  int          rise_log[$];
  longint      fall_t[$];
  longint      sclk_t[$];

  always @(adc_cs_n or adc_sclk) begin
    if (prev_cs == 1'b1 && adc_cs_n == 1'b0) begin
      adc_dout      = pending[11];
      tx_sr         = pending << 1;
      rx_sr         = 12'd0;
      rise_in_frame = 0;
      fall_cnt++;
      t_fall = longint'($time);
      fall_t.push_back(longint'($time));
    end else if (prev_cs == 1'b0 && adc_cs_n == 1'b1) begin
      cfg_w = rx_sr[11:6];
      cfg_log.push_back(cfg_w);
      low_log.push_back(int'((longint'($time) - t_fall) / CLK_P));
      rise_log.push_back(rise_in_frame);
      pending = 12'hA00 + {9'd0, cfg_w[3], cfg_w[2], cfg_w[4]};
    end
    if (adc_cs_n == 1'b0 && prev_cs == 1'b0 && prev_sclk == 1'b1 && adc_sclk == 1'b0) begin
      adc_dout = tx_sr[11];
      tx_sr    = tx_sr << 1;
    end
    if (prev_sclk == 1'b0 && adc_sclk == 1'b1) begin
      rx_sr = {rx_sr[10:0], adc_din};
      rise_in_frame++;
      sclk_t.push_back(longint'($time));
    end
    prev_cs   = adc_cs_n;
    prev_sclk = adc_sclk;
  end

  // ---------------- checking and bus tasks ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All bus tasks start just after a falling clock edge and end on one.
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    bus.avs_address   = a;
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(negedge clk);
    bus.avs_write     = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [31:0] d);
    bus.avs_address = a;
    bus.avs_read    = 1'b1;
    @(negedge clk);
    bus.avs_read    = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic wait_cs(input logic want_rise, input int n, input int budget, input string tag);
    int   seen;
    logic prev;
    seen = 0;
    prev = adc_cs_n;
    for (int c = 0; (c < budget) && (seen < n); c++) begin
      @(negedge clk);
      if (want_rise ? (!prev && adc_cs_n) : (prev && !adc_cs_n)) seen++;
      prev = adc_cs_n;
    end
    check_eq(tag, 32'(seen), 32'(n));
  endtask

  task automatic wait_irq(input int budget, input string tag);
    int c;
    c = 0;
    while (bus.irq !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    check_eq(tag, {31'd0, bus.irq}, 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [31:0] d;
    int base, f0;

    bus.avs_address   = 4'd0;
    bus.avs_read      = 1'b0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = 32'd0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1. Reset state
    check_eq("rst_cs_n", {31'd0, adc_cs_n}, 32'd1);
    check_eq("rst_sclk", {31'd0, adc_sclk}, 32'd0);
    check_eq("rst_din",  {31'd0, adc_din},  32'd0);
    check_eq("rst_irq",  {31'd0, bus.irq},  32'd0);
    check_eq("rst_rdata", bus.avs_readdata, 32'd0);
    rd(4'd1, d);
    check_eq("rst_status", d, 32'd0);
    for (int i = 0; i < 8; i++) begin
      rd(4'(8 + i), d);
      check_eq($sformatf("rst_result%0d", i), d, 32'd0);
    end

    // 1b. Reset in the SHIFT phase of frame 1 aborts it
    wr(4'd0, 32'h0000_0101);
    wait_cs(1'b0, 2, 600, "mid_frame1_fall");
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_cs_n", {31'd0, adc_cs_n}, 32'd1);
    check_eq("abort_sclk", {31'd0, adc_sclk}, 32'd0);
    check_eq("abort_din",  {31'd0, adc_din},  32'd0);
    reset = 1'b0;
    rd(4'd8, d);
    check_eq("abort_result0", d, 32'd0);
    rd(4'd1, d);
    check_eq("abort_status", d, 32'd0);

    // 2./3. Single-shot sweep of channels 0 and 2, with pin timing
    base = cfg_log.size();
    f0   = fall_t.size();
    wr(4'd0, 32'h0000_0505);
    wait_irq(1000, "ss_irq");
    check_eq("ss_frames", 32'(cfg_log.size() - base), 32'd3);
    check_eq("ss_cfg0", {26'd0, cfg_log[base]},     32'h22);
    check_eq("ss_cfg1", {26'd0, cfg_log[base + 1]}, 32'h26);
    check_eq("ss_cfg2", {26'd0, cfg_log[base + 2]}, 32'h26);
    check_eq("t_cs_low",   32'(low_log[base]),  32'd96);
    check_eq("t_sclk_rise", 32'(rise_log[base]), 32'd12);
    check_eq("t_frame", 32'((fall_t[f0 + 1] - fall_t[f0]) / CLK_P), 32'd177);
    check_eq("t_sclk_per", 32'((sclk_t[sclk_t.size() - 1] - sclk_t[sclk_t.size() - 2]) / CLK_P), 32'd8);
    rd(4'd8, d);
    check_eq("ss_result0", d, 32'h8000_0A00);
    rd(4'd10, d);
    check_eq("ss_result2", d, 32'h8000_0A02);
    rd(4'd9, d);
    check_eq("ss_result1", d, 32'd0);
    rd(4'd1, d);
    check_eq("ss_status", d, 32'h2);
    check_eq("ss_irq_hold", {31'd0, bus.irq}, 32'd1);
    rd(4'd8, d);
    check_eq("ss_result0_reread", d, 32'h0000_0A00);
    rd(4'd0, d);
    check_eq("ss_ctrl", d, 32'h0000_0504);

    // 4. Ignored starts
    wr(4'd1, 32'h2);
    f0 = fall_cnt;
    wr(4'd0, 32'h0000_0001);
    repeat (200) @(negedge clk);
    rd(4'd1, d);
    check_eq("nomask_status", d, 32'd0);
    check_eq("nomask_frames", 32'(fall_cnt - f0), 32'd0);
    f0 = fall_cnt;
    wr(4'd0, 32'h0000_0105);
    repeat (10) @(negedge clk);
    wr(4'd0, 32'h0000_FF05);
    wait_irq(1000, "busy_start_irq");
    repeat (5) @(negedge clk);
    check_eq("busy_start_frames", 32'(fall_cnt - f0), 32'd2);
    rd(4'd0, d);
    check_eq("busy_start_ctrl", d, 32'h0000_FF04);
    rd(4'd1, d);
    check_eq("busy_start_status", d, 32'h2);

    // 5. Continuous mode on channel 7
    wr(4'd1, 32'h2);
    f0   = fall_cnt;
    base = cfg_log.size();
    wr(4'd0, 32'h0000_8007);
    wait_irq(800, "cont_irq1");
    rd(4'd1, d);
    check_eq("cont_status1", d, 32'h3);
    wr(4'd1, 32'h2);
    check_eq("w1c_irq_lag", {31'd0, bus.irq}, 32'd1);
    @(negedge clk);
    check_eq("w1c_irq_drop", {31'd0, bus.irq}, 32'd0);
    wr(4'd0, 32'h0000_8004);
    wait_irq(800, "cont_irq2");
    rd(4'd1, d);
    check_eq("cont_status2", d, 32'h2);
    check_eq("cont_frames", 32'(fall_cnt - f0), 32'd4);
    check_eq("cont_cfg", {26'd0, cfg_log[base]}, 32'h3E);
    repeat (400) @(negedge clk);
    check_eq("cont_stopped", 32'(fall_cnt - f0), 32'd4);
    rd(4'd15, d);
    check_eq("cont_result7", d, 32'h8000_0A07);

    // 6. Read of RESULT0 in the same cycle STORE writes it
    wr(4'd1, 32'h2);
    rd(4'd8, d);
    check_eq("coll_pre", d, 32'h8000_0A00);
    wr(4'd0, 32'h0000_0101);
    wait_cs(1'b1, 2, 600, "coll_rise");
    rd(4'd8, d);
    check_eq("coll_same_cycle", d, 32'h0000_0A00);
    rd(4'd8, d);
    check_eq("coll_valid_kept", d, 32'h8000_0A00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
